mbldcm_startup_sequencer: RTL and testbench



---
 rtl/mbldcm_seq_pkg.sv | 29 ++
 rtl/mbldcm_seq_interval_timer.sv | 30 +++
 rtl/mbldcm_startup_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mbldcm_startup_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mbldcm_seq_pkg.sv
// Shared types and helpers for the BLDC open-loop start-up sequencer.
// State encodings double as the oState monitoring code.
package mbldcm_seq_pkg;

  localparam int cDefPwmCounterWidth = 32;
  localparam int cDefDivWidth        = 32;
  localparam int cDefTimerWidth      = 32;
  localparam int cArithWidth         = 64;

  typedef enum logic [2:0] {
    sIdle  = 3'd0,
    sLoad  = 3'd1,
    sAlign = 3'd2,
    sRamp  = 3'd3,
    sRun   = 3'd4
  } seqState_t;

  // value - dec, clamped below at floorVal and never wrapping past zero.
  function automatic logic [cArithWidth-1:0] satSubFloor(
    input logic [cArithWidth-1:0] value,
    input logic [cArithWidth-1:0] dec,
    input logic [cArithWidth-1:0] floorVal
  );
    logic [cArithWidth-1:0] diff;
    diff = (value > dec) ? (value - dec) : '0;
    return (diff < floorVal) ? floorVal : diff;
  endfunction

endpackage

// File: rtl/mbldcm_seq_interval_timer.sv
// Loadable down-counter; oExpire is high for the one cycle in which the count is 1,
// so a load of N gives an expiry N cycles after the load edge.
module mbldcm_seq_interval_timer #(
  parameter int pWidth = 32
) (
  input  logic              iClock,
  input  logic              iReset_n,
  input  logic              iClear,
  input  logic              iLoad,
  input  logic [pWidth-1:0] iLoadValue,
  output logic              oExpire
);

  logic [pWidth-1:0] count;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      count <= '0;
    end else if (iClear) begin
      count <= '0;
    end else if (iLoad) begin
      count <= iLoadValue;
    end else if (count != '0) begin
      count <= count - pWidth'(1);
    end
  end

  assign oExpire = (count == pWidth'(1));

endmodule

// File: rtl/mbldcm_startup_sequencer.sv
// Open-loop align / divider-ramp / run sequencer driving the BLDC core controls.
// Define MBLDCM_SEQ_CMP_RAMP_EN to ramp the PWM compare from CmpAlign to CmpRun during RAMP.
module mbldcm_startup_sequencer
  import mbldcm_seq_pkg::*;
#(
  parameter int pPwmCounterWidth = cDefPwmCounterWidth,
  parameter int pDivWidth        = cDefDivWidth,
  parameter int pTimerWidth      = cDefTimerWidth
) (
  input  logic                        iClock,
  input  logic                        iReset_n,
  input  logic                        iStart,
  input  logic                        iAbort,
  input  logic [2:0]                  iAlignPhase,
  input  logic [pTimerWidth-1:0]      iAlignCycles,
  input  logic [pDivWidth-1:0]        iDivStart,
  input  logic [pDivWidth-1:0]        iDivTarget,
  input  logic [pDivWidth-1:0]        iDivStep,
  input  logic [pTimerWidth-1:0]      iStepInterval,
  input  logic [pPwmCounterWidth-1:0] iCmpAlign,
  input  logic [pPwmCounterWidth-1:0] iCmpRun,
  output logic                        oEnable,
  output logic                        oStop,
  output logic [pDivWidth-1:0]        oDiv,
  output logic [2:0]                  oPhaseUpdate,
  output logic                        oLatchPhaseUpdate,
  output logic [pPwmCounterWidth-1:0] oPwmCmpCnt,
  output logic                        oBusy,
  output logic                        oRunning,
  output logic [2:0]                  oState
);

  seqState_t state, nextState;

  logic [pTimerWidth-1:0]      alignCycles, stepInterval;
  logic [pDivWidth-1:0]        divStart, divTarget, divStep;
  logic [pPwmCounterWidth-1:0] cmpAlign, cmpRun;

  logic startAccept, enterAlign, enterRamp, rampStep, rampDone;
  logic timerClear, alignLoad, stepLoad, alignExpire, stepExpire;
  logic [pDivWidth-1:0]        nextDiv;
  logic [pPwmCounterWidth-1:0] rampEntryCmp;

  // Configuration snapshot taken on the IDLE->LOAD edge; zero step/interval become 1.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      alignCycles  <= '0;
      stepInterval <= '0;
      divStart     <= '0;
      divTarget    <= '0;
      divStep      <= '0;
      cmpAlign     <= '0;
      cmpRun       <= '0;
    end else if (startAccept) begin
      alignCycles  <= iAlignCycles;
      stepInterval <= (iStepInterval == '0) ? pTimerWidth'(1) : iStepInterval;
      divStart     <= iDivStart;
      divTarget    <= iDivTarget;
      divStep      <= (iDivStep == '0) ? pDivWidth'(1) : iDivStep;
      cmpAlign     <= iCmpAlign;
      cmpRun       <= iCmpRun;
    end
  end

  mbldcm_seq_interval_timer #(.pWidth(pTimerWidth)) alignTimer (
    .iClock     (iClock),
    .iReset_n   (iReset_n),
    .iClear     (timerClear),
    .iLoad      (alignLoad),
    .iLoadValue (alignCycles),
    .oExpire    (alignExpire)
  );

  mbldcm_seq_interval_timer #(.pWidth(pTimerWidth)) stepTimer (
    .iClock     (iClock),
    .iReset_n   (iReset_n),
    .iClear     (timerClear),
    .iLoad      (stepLoad),
    .iLoadValue (stepInterval),
    .oExpire    (stepExpire)
  );

`ifdef MBLDCM_SEQ_CMP_RAMP_EN
  logic [pPwmCounterWidth-1:0] cmpToward;
  always_comb begin
    cmpToward = oPwmCmpCnt;
    if (oPwmCmpCnt < cmpRun) begin
      cmpToward = oPwmCmpCnt + pPwmCounterWidth'(1);
    end else if (oPwmCmpCnt > cmpRun) begin
      cmpToward = oPwmCmpCnt - pPwmCounterWidth'(1);
    end
  end
  assign rampEntryCmp = cmpAlign;
  assign rampDone     = (oDiv == divTarget) && (oPwmCmpCnt == cmpRun);
`else
  assign rampEntryCmp = cmpRun;
  assign rampDone     = (oDiv == divTarget);
`endif

  always_comb begin
    nextState = state;
    case (state)
      sIdle:   if (iStart) nextState = sLoad;
      sLoad:   nextState = (alignCycles == '0) ? sRamp : sAlign;
      sAlign:  if (alignExpire) nextState = sRamp;
      sRamp:   if (rampDone) nextState = sRun;
      sRun:    nextState = sRun;
      default: nextState = sIdle;
    endcase
    if (iAbort) nextState = sIdle;
  end

  assign startAccept = (state == sIdle) && (nextState == sLoad);
  assign enterAlign  = (state == sLoad) && (nextState == sAlign);
  assign enterRamp   = (state != sRamp) && (nextState == sRamp);
  assign rampStep    = (state == sRamp) && (nextState == sRamp) && stepExpire;
  assign timerClear  = (nextState == sIdle);
  assign alignLoad   = enterAlign;
  assign stepLoad    = enterRamp || rampStep;
  assign nextDiv     = pDivWidth'(satSubFloor(cArithWidth'(oDiv), cArithWidth'(divStep),
                                              cArithWidth'(divTarget)));

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= sIdle;
    end else begin
      state <= nextState;
    end
  end

  // Outputs are registered from nextState so they line up with the state they describe.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      oEnable           <= 1'b0;
      oStop             <= 1'b1;
      oDiv              <= '0;
      oPhaseUpdate      <= '0;
      oLatchPhaseUpdate <= 1'b0;
      oPwmCmpCnt        <= '0;
      oBusy             <= 1'b0;
      oRunning          <= 1'b0;
    end else begin
      oEnable           <= (nextState inside {sAlign, sRamp, sRun});
      oStop             <= !(nextState inside {sRamp, sRun});
      oLatchPhaseUpdate <= (nextState == sLoad);
      oBusy             <= (nextState != sIdle);
      oRunning          <= (nextState == sRun);

      if (startAccept) begin
        oPhaseUpdate <= iAlignPhase;
        oDiv         <= iDivStart;
      end else if (enterRamp) begin
        if (divStart <= divTarget) oDiv <= divTarget;
      end else if (rampStep) begin
        oDiv <= nextDiv;
      end

      if (enterAlign) begin
        oPwmCmpCnt <= cmpAlign;
      end else if (enterRamp) begin
        oPwmCmpCnt <= rampEntryCmp;
`ifdef MBLDCM_SEQ_CMP_RAMP_EN
      end else if (rampStep) begin
        oPwmCmpCnt <= cmpToward;
`endif
      end
    end
  end

  assign oState = state;

endmodule

// File: tb/tb_mbldcm_startup_sequencer.sv
// Scoreboard bench: every change of the output vector is an event checked against
// a queue of hand-computed snapshots, including the cycle gap since the previous event.
module tb_mbldcm_startup_sequencer;

  localparam int W = 83;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [2:0]  align_phase;
  logic [31:0] align_cycles, div_start, div_target, div_step, step_interval;
  logic [31:0] cmp_align, cmp_run;
  logic        o_enable, o_stop, o_latch, o_busy, o_running;
  logic [31:0] o_div, o_cmp;
  logic [2:0]  o_phase, o_state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mbldcm_startup_sequencer dut (
    .iClock            (clk),
    .iReset_n          (rst_n),
    .iStart            (start),
    .iAbort            (abort),
    .iAlignPhase       (align_phase),
    .iAlignCycles      (align_cycles),
    .iDivStart         (div_start),
    .iDivTarget        (div_target),
    .iDivStep          (div_step),
    .iStepInterval     (step_interval),
    .iCmpAlign         (cmp_align),
    .iCmpRun           (cmp_run),
    .oEnable           (o_enable),
    .oStop             (o_stop),
    .oDiv              (o_div),
    .oPhaseUpdate      (o_phase),
    .oLatchPhaseUpdate (o_latch),
    .oPwmCmpCnt        (o_cmp),
    .oBusy             (o_busy),
    .oRunning          (o_running),
    .oState            (o_state)
  );

  // gap 0 means the cycle spacing is not checked for that event
  task automatic expect_ev(input int gap, input int st, input bit en, input bit stp,
                           input bit lat, input bit bsy, input bit run, input int ph,
                           input int dv, input int cm);
    exp_q.push_back({8'(gap), 3'(st), en, stp, lat, bsy, run, 3'(ph), 32'(dv), 32'(cm)});
  endtask

  task automatic set_cfg(input int ph, input int ac, input int ds, input int dt,
                         input int dst, input int si, input int ca, input int cr);
    align_phase   = 3'(ph);
    align_cycles  = 32'(ac);
    div_start     = 32'(ds);
    div_target    = 32'(dt);
    div_step      = 32'(dst);
    step_interval = 32'(si);
    cmp_align     = 32'(ca);
    cmp_run       = 32'(cr);
  endtask

  // start is seen by the edge this task waits on (edge E0 of the sequence)
  task automatic start_seq();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic abort_now();
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  // monitor
  initial begin
    logic [74:0]  cur_v, prev_v;
    logic [W-1:0] e;
    int cyc, last_cyc, gap, ev;
    bit seen;
    cyc = 0; last_cyc = 0; ev = 0; seen = 1'b0; prev_v = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cyc++;
        cur_v = {o_state, o_enable, o_stop, o_latch, o_busy, o_running, o_phase, o_div, o_cmp};
        if (!seen || cur_v != prev_v) begin
          gap = seen ? (cyc - last_cyc) : 0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL ev%0d unexpected output change got=%h", ev, cur_v);
          end else begin
            e = exp_q.pop_front();
            if (e[74:0] != cur_v || (e[82:75] != 8'd0 && int'(e[82:75]) != gap)) begin
              bad++;
              $display("FAIL ev%0d got=%h gap=%0d want=%h gap=%0d",
                       ev, cur_v, gap, e[74:0], int'(e[82:75]));
            end
          end
          ev++;
          seen     = 1'b1;
          prev_v   = cur_v;
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    expect_ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // alignment of 4 cycles, ramp 100->75->50->40 every 3 clocks, run
    set_cfg(2, 4, 100, 40, 25, 3, 9, 9);
    expect_ev(0, 1, 0, 1, 1, 1, 0, 2, 100, 0);
    expect_ev(1, 2, 1, 1, 0, 1, 0, 2, 100, 9);
    expect_ev(4, 3, 1, 0, 0, 1, 0, 2, 100, 9);
    expect_ev(3, 3, 1, 0, 0, 1, 0, 2, 75, 9);
    expect_ev(3, 3, 1, 0, 0, 1, 0, 2, 50, 9);
    expect_ev(3, 3, 1, 0, 0, 1, 0, 2, 40, 9);
    expect_ev(1, 4, 1, 0, 0, 1, 1, 2, 40, 9);
    expect_ev(0, 0, 0, 1, 0, 0, 0, 2, 40, 9);
    start_seq();
    repeat (6) @(posedge clk);
    #1 set_cfg(5, 1, 7, 10, 1, 7, 3, 3);
    repeat (11) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    abort_now();
    repeat (3) @(posedge clk);

    // abort in the middle of the ramp, then start+abort together while idle
    set_cfg(1, 2, 200, 100, 10, 4, 9, 9);
    expect_ev(0, 1, 0, 1, 1, 1, 0, 1, 200, 9);
    expect_ev(1, 2, 1, 1, 0, 1, 0, 1, 200, 9);
    expect_ev(2, 3, 1, 0, 0, 1, 0, 1, 200, 9);
    expect_ev(4, 3, 1, 0, 0, 1, 0, 1, 190, 9);
    expect_ev(2, 0, 0, 1, 0, 0, 0, 1, 190, 9);
    start_seq();
    repeat (8) @(posedge clk);
    abort_now();
    #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    repeat (3) @(posedge clk);

    // start divider already at or below target, no alignment
    set_cfg(6, 0, 30, 40, 5, 2, 9, 9);
    expect_ev(0, 1, 0, 1, 1, 1, 0, 6, 30, 9);
    expect_ev(1, 3, 1, 0, 0, 1, 0, 6, 40, 9);
    expect_ev(1, 4, 1, 0, 0, 1, 1, 6, 40, 9);
    expect_ev(0, 0, 0, 1, 0, 0, 0, 6, 40, 9);
    start_seq();
    repeat (4) @(posedge clk);
    abort_now();
    repeat (3) @(posedge clk);

`ifdef MBLDCM_SEQ_CMP_RAMP_EN
    // compare ramps 10->13 one count per step; divider done after the first step
    set_cfg(4, 1, 60, 50, 10, 2, 10, 13);
    expect_ev(0, 1, 0, 1, 1, 1, 0, 4, 60, 9);
    expect_ev(1, 2, 1, 1, 0, 1, 0, 4, 60, 10);
    expect_ev(1, 3, 1, 0, 0, 1, 0, 4, 60, 10);
    expect_ev(2, 3, 1, 0, 0, 1, 0, 4, 50, 11);
    expect_ev(2, 3, 1, 0, 0, 1, 0, 4, 50, 12);
    expect_ev(2, 3, 1, 0, 0, 1, 0, 4, 50, 13);
    expect_ev(1, 4, 1, 0, 0, 1, 1, 4, 50, 13);
    expect_ev(0, 0, 0, 1, 0, 0, 0, 4, 50, 13);
    start_seq();
    repeat (12) @(posedge clk);
    abort_now();
`else
    // one-cycle alignment at CmpAlign, compare jumps to CmpRun on ramp entry
    set_cfg(3, 1, 50, 50, 5, 2, 7, 20);
    expect_ev(0, 1, 0, 1, 1, 1, 0, 3, 50, 9);
    expect_ev(1, 2, 1, 1, 0, 1, 0, 3, 50, 7);
    expect_ev(1, 3, 1, 0, 0, 1, 0, 3, 50, 20);
    expect_ev(1, 4, 1, 0, 0, 1, 1, 3, 50, 20);
    expect_ev(0, 0, 0, 1, 0, 0, 0, 3, 50, 20);
    start_seq();
    repeat (5) @(posedge clk);
    abort_now();
`endif

    repeat (5) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
